// File: rtl/sd_timer.sv
// Loadable WIDTH-bit down-counter with a registered terminal-count pulse.
// Supports one-shot and auto-reload (periodic tick) modes; load has top priority.
module sd_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] r_reg,
  output logic             tc,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_next;
  logic             tc_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      r_reg      <= ZERO;
      reload_reg <= ZERO;
      tc         <= 1'b0;
    end else begin
      state      <= state_next;
      r_reg      <= count_next;
      reload_reg <= reload_next;
      tc         <= tc_next;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the if-tree leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    count_next  = r_reg;
    reload_next = reload_reg;
    tc_next     = 1'b0;

    if (load) begin
      // A load always wins, including over a terminal cycle, so tc stays low.
      count_next  = load_val;
      reload_next = load_val;
      state_next  = (load_val != ZERO) ? RUN : IDLE;
    end else if (state == RUN && en) begin
      if (r_reg > ONE) begin
        count_next = r_reg - ONE;
      end else if (r_reg == ONE) begin
        tc_next = 1'b1;
        if (auto_reload) begin
          count_next = reload_reg;
        end else begin
          count_next = ZERO;
          state_next = IDLE;
        end
      end else begin
        // RUN with a zero count cannot be entered; fall back to IDLE rather than wrap.
        state_next = IDLE;
      end
    end
  end

  // busy is a pure decode of the state flop, so it has no path from the inputs.
  assign busy = (state == RUN);

endmodule

// File: tb/tb_sd_timer.sv
// Self-checking bench for sd_timer: directed scenarios plus a randomized run
// compared against a remaining-edges reference model.
module tb_sd_timer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;
  logic [WIDTH-1:0] r_reg;
  logic             tc;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: count value, reload value, running flag, pending tc.
  int m_cnt;
  int m_rl;
  bit m_run;
  bit m_tc;

  sd_timer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
    .auto_reload(auto_reload),
    .r_reg      (r_reg),
    .tc         (tc),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, r_reg=%0d tc=%0b busy=%0b", r_reg, tc, busy);
    $fatal(1, "watchdog expired");
  end

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a load of N schedules tc after N enabled edges; reaching zero
  // remaining edges either reloads (periodic) or stops (one-shot).
  task automatic model_edge(input bit e, input bit ld, input bit ar, input int lv);
    if (ld) begin
      m_cnt = lv;
      m_rl  = lv;
      m_run = (lv != 0);
      m_tc  = 1'b0;
    end else if (m_run && e) begin
      m_cnt = m_cnt - 1;
      m_tc  = 1'b0;
      if (m_cnt == 0) begin
        m_tc = 1'b1;
        if (ar) m_cnt = m_rl;
        else    m_run = 1'b0;
      end
    end else begin
      m_tc = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; load = 1'b0; load_val = '0; auto_reload = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if ({r_reg, tc, busy} !== {4'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got r_reg=%0d tc=%0b busy=%0b, want 0 0 0", k, r_reg, tc, busy);
      end
    end
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if ({r_reg, tc, busy} !== {4'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL idle_hold[%0d]: got r_reg=%0d tc=%0b busy=%0b, want 0 0 0", k, r_reg, tc, busy);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [3:0] exp_r [7] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    logic       exp_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_b [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    en = 1'b0; load = 1'b1; load_val = 4'd5; auto_reload = 1'b0;
    step();
    n_checks++;
    if ({r_reg, tc, busy} !== {4'd5, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL one_shot_load: got r_reg=%0d tc=%0b busy=%0b, want 5 0 1", r_reg, tc, busy);
    end
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      n_checks++;
      if ({r_reg, tc, busy} !== {exp_r[k], exp_t[k], exp_b[k]}) begin
        n_fail++;
        $display("FAIL one_shot[%0d]: got r_reg=%0d tc=%0b busy=%0b, want %0d %0b %0b",
                 k, r_reg, tc, busy, exp_r[k], exp_t[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_auto_reload();
    logic [3:0] er;
    logic       et;
    en = 1'b0; load = 1'b1; load_val = 4'd3; auto_reload = 1'b1;
    step();
    n_checks++;
    if ({r_reg, tc, busy} !== {4'd3, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reload_load: got r_reg=%0d tc=%0b busy=%0b, want 3 0 1", r_reg, tc, busy);
    end
    load = 1'b0; en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      er = 4'(3 - (k % 3));
      et = (k % 3 == 0);
      n_checks++;
      if ({r_reg, tc, busy} !== {er, et, 1'b1}) begin
        n_fail++;
        $display("FAIL reload[%0d]: got r_reg=%0d tc=%0b busy=%0b, want %0d %0b 1", k, r_reg, tc, busy, er, et);
      end
    end
    // N=1 periodic: a tick on every enabled cycle.
    load = 1'b1; load_val = 4'd1; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if ({r_reg, tc, busy} !== {4'd1, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL reload_n1[%0d]: got r_reg=%0d tc=%0b busy=%0b, want 1 1 1", k, r_reg, tc, busy);
      end
    end
  endtask

  task automatic test_enable_gaps();
    logic       pat   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp_r [6] = '{4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
    en = 1'b0; load = 1'b1; load_val = 4'd4; auto_reload = 1'b0;
    step();
    load = 1'b0;
    for (int k = 0; k < 6; k++) begin
      en = pat[k];
      step();
      n_checks++;
      if ({r_reg, tc, busy} !== {exp_r[k], (k == 5), (k != 5)}) begin
        n_fail++;
        $display("FAIL gaps[%0d]: got r_reg=%0d tc=%0b busy=%0b, want %0d %0b %0b",
                 k, r_reg, tc, busy, exp_r[k], (k == 5), (k != 5));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_priority();
    en = 1'b0; load = 1'b1; load_val = 4'd9; auto_reload = 1'b0;
    step();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 8; k++) step();
    n_checks++;
    if ({r_reg, tc, busy} !== {4'd1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL prio_setup: got r_reg=%0d tc=%0b busy=%0b, want 1 0 1", r_reg, tc, busy);
    end
    load = 1'b1; load_val = 4'd9;
    step();
    n_checks++;
    if ({r_reg, tc, busy} !== {4'd9, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL prio_load_over_tc: got r_reg=%0d tc=%0b busy=%0b, want 9 0 1", r_reg, tc, busy);
    end
    load_val = 4'd0;
    step();
    n_checks++;
    if ({r_reg, tc, busy} !== {4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL load_zero: got r_reg=%0d tc=%0b busy=%0b, want 0 0 0", r_reg, tc, busy);
    end
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if ({r_reg, tc, busy} !== {4'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL load_zero_hold[%0d]: got r_reg=%0d tc=%0b busy=%0b, want 0 0 0", k, r_reg, tc, busy);
      end
    end
    load = 1'b1; load_val = 4'd15;
    step();
    load = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      n_checks++;
      if ({r_reg, tc, busy} !== {4'((k >= 15) ? 0 : 15 - k), (k == 15), (k < 15)}) begin
        n_fail++;
        $display("FAIL max_load[%0d]: got r_reg=%0d tc=%0b busy=%0b, want %0d %0b %0b",
                 k, r_reg, tc, busy, (k >= 15) ? 0 : 15 - k, (k == 15), (k < 15));
      end
    end
  endtask

  task automatic test_async_reset();
    en = 1'b0; load = 1'b1; load_val = 4'd8; auto_reload = 1'b0;
    step();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 3; k++) step();
    n_checks++;
    if ({r_reg, tc, busy} !== {4'd5, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL areset_setup: got r_reg=%0d tc=%0b busy=%0b, want 5 0 1", r_reg, tc, busy);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({r_reg, tc, busy} !== {4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL areset_immediate: got r_reg=%0d tc=%0b busy=%0b, want 0 0 0", r_reg, tc, busy);
    end
    #1 reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++;
      if ({r_reg, tc, busy} !== {4'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL areset_abort[%0d]: got r_reg=%0d tc=%0b busy=%0b, want 0 0 0", k, r_reg, tc, busy);
      end
    end
  endtask

  task automatic test_random();
    bit e, ld, ar;
    int lv;
    m_cnt = 0; m_rl = 0; m_run = 1'b0; m_tc = 1'b0;
    ar = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        #2;
        reset = 1'b1;
        m_cnt = 0; m_rl = 0; m_run = 1'b0; m_tc = 1'b0;
      end
      e  = ($urandom_range(0, 9) < 7);
      ld = (k == 0) || ($urandom_range(0, 19) == 0);
      lv = (ld && $urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) ar = ~ar;
      en = e; load = ld; load_val = 4'(lv); auto_reload = ar;
      @(posedge clk);
      model_edge(e, ld, ar, lv);
      #1;
      n_checks++;
      if ({r_reg, tc, busy} !== {4'(m_cnt), m_tc, m_run}) begin
        n_fail++;
        $display("FAIL random[%0d]: got r_reg=%0d tc=%0b busy=%0b, want %0d %0b %0b",
                 k, r_reg, tc, busy, m_cnt, m_tc, m_run);
      end
    end
    en = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_enable_gaps();
    test_priority();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_timer.md
Name: sd_timer

Overview:
- Loadable down-counter/timer; the counting-down counterpart to the team's 4-bit enable-gated up counter (`sc`).
- Software or an FSM loads a start value. The block decrements on enabled cycles and flags terminal count.
- Supports one-shot and auto-reload (periodic tick) modes.
- Used as a delay/timeout generator next to the up counter in flip-flop/counter labs.

Parameters:
- WIDTH, 4, counter and load-value width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable; decrement only when high.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  start/reload value sampled when load=1.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled at terminal count.
- r_reg  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, high for exactly one cycle.
- busy  output  1  high while the state is RUN.

Behaviour:
- Reset
  - reset low, asynchronously: r_reg=0, reload register=0, tc=0, busy=0, state=IDLE.
  - Deassertion takes effect at the next rising clk.
  - Reset mid-count aborts the count; no tc is produced.
- States
  - IDLE: busy=0, r_reg holds, en ignored. Counter never wraps below 0.
  - RUN: busy=1.
- Load (highest priority, any state)
  - On a clk edge with load=1: r_reg<=load_val and reload register<=load_val, regardless of en.
  - load_val!=0: state<=RUN.
  - load_val==0: state<=IDLE, tc stays 0.
  - Load during RUN restarts the count.
  - Load in the same cycle as a would-be terminal count wins; tc is not asserted.
- Counting, RUN with en=1 and load=0
  - r_reg>1: r_reg<=r_reg-1, tc<=0.
  - r_reg==1 (terminal cycle): tc<=1.
    - auto_reload=1: r_reg<=reload register, stay in RUN.
    - auto_reload=0: r_reg<=0, state<=IDLE (busy falls the same edge).
- RUN with en=0: r_reg and state hold, tc<=0.
- Timing
  - tc is high in the cycle following the terminal edge only; it is cleared on every other edge.
  - One-shot latency: N enabled edges after load of N, r_reg=0 and tc=1.
  - Auto-reload period: tc every N enabled edges.
  - N=1: tc is high on every enabled cycle.
  - Gaps in en stretch the period without losing counts.
- Arithmetic: unsigned, WIDTH bits.
  - Maximum load value is 2^WIDTH-1, giving 2^WIDTH-1 enabled edges to terminal.
  - Decrement below 0 never occurs.
- Outputs are driven only from flops; no combinational path from inputs to outputs.

Test Plan:
1. Reset and idle hold:
   - Stimulus: reset low 2 cycles, then release; en=1, no load, 5 cycles.
   - Required: r_reg=0, tc=0, busy=0 throughout.
2. One-shot, N=5:
   - Stimulus: load_val=5, auto_reload=0, load 1 cycle, then en=1.
   - Required: r_reg=5,4,3,2,1,0; tc=1 for exactly one cycle together with r_reg=0; busy 1→0 on the same edge; counter stays 0 afterwards.
3. Auto-reload, N=3, en held high 12 cycles:
   - Required: r_reg 3,2,1,3,2,1,...; tc pulses every 3rd cycle; busy stays 1.
4. Enable gaps:
   - Stimulus: load 4, en pattern 1,0,0,1,1,1.
   - Required: r_reg holds at 3 during the gaps; tc only after the 4th enabled edge.
5. Priority and corner loads:
   - Stimulus: load 9 while r_reg==1 and en=1.
   - Required: r_reg=9, no tc.
   - Stimulus: load 0.
   - Required: IDLE, busy=0, no tc.
   - Stimulus: load 15, en high.
   - Required: tc after 15 edges.
6. Async reset mid-count:
   - Stimulus: load 8, count to 5, pulse reset low between clk edges.
   - Required: r_reg, tc and busy go to 0 immediately, before the next edge.
